// File: rtl/otter_mmio_hub.sv
// otter_mmio_hub
// Memory-mapped I/O hub between the OTTER MCU IOBUS and board peripherals.
// Slot k lives at BASE + (k << SLOT_SH). The map is laid out as follows:
//   slots 0..N_IN-1          synchronised input channels (read only)
//   slots N_IN..N_IN+N_OUT-1 output registers with a one-cycle write strobe
//   slot  S = N_IN+N_OUT     IRQ_PEND (read, write-1-to-clear)
//   slot  S+1                IRQ_MASK (read/write)
// Any other address reads as 0 and ignores writes.
//
// Ports:
//   CLK, RST_N      MCU clock, asynchronous active-low reset
//   IOBUS_ADDR      bus address
//   IOBUS_OUT       write data from the MCU
//   IOBUS_WR        write enable
//   IOBUS_IN        combinational read data to the MCU
//   IN_DATA         raw peripheral inputs, channel i = [i*W +: W]
//   OUT_DATA        output registers, channel j = [j*W +: W]
//   OUT_STB         per-slot write strobe, high for the cycle after a write
//   IRQ             registered interrupt request (pending & mask)
//
// Build option:
//   MMIO_HUB_SYNC_EN  defined   : two-flop synchroniser on every IN_DATA bit
//                     undefined : single register stage on IN_DATA
module otter_mmio_hub #(
    parameter int          N_OUT   = 4,
    parameter int          N_IN    = 2,
    parameter int          W       = 16,
    parameter logic [31:0] BASE    = 32'h1100_0000,
    parameter int          SLOT_SH = 18
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [31:0]         IOBUS_ADDR,
    input  logic [31:0]         IOBUS_OUT,
    input  logic                IOBUS_WR,
    output logic [31:0]         IOBUS_IN,
    input  logic [N_IN*W-1:0]   IN_DATA,
    output logic [N_OUT*W-1:0]  OUT_DATA,
    output logic [N_OUT-1:0]    OUT_STB,
    output logic                IRQ
);

    localparam int          S        = N_IN + N_OUT;
    localparam logic [31:0] LOW_MASK = (32'd1 << SLOT_SH) - 32'd1;

    // Address decode: the offset from BASE must be an exact multiple of the
    // slot spacing. Addresses below BASE wrap to a huge slot number and fall
    // out of range naturally.
    logic [31:0] offset;
    logic [31:0] slot;
    logic        mapped;

    assign offset = IOBUS_ADDR - BASE;
    assign slot   = offset >> SLOT_SH;
    assign mapped = ((offset & LOW_MASK) == 32'd0) && (slot < 32'(S + 2));

    // Only IOBUS_OUT[W-1:0] is stored by output slots.
    logic unused_bits;
    assign unused_bits = ^IOBUS_OUT;

    logic [N_IN*W-1:0]  sync_q, sync_d;
`ifdef MMIO_HUB_SYNC_EN
    logic [N_IN*W-1:0]  meta_q, meta_d;
`endif
    logic [N_IN-1:0]    prev_q, prev_d;
    logic [N_IN-1:0]    pend_q, pend_d;
    logic [N_IN-1:0]    mask_q, mask_d;
    logic               irq_q, irq_d;
    logic [N_OUT*W-1:0] out_data_q, out_data_d;
    logic [N_OUT-1:0]   out_stb_q, out_stb_d;

    logic [N_IN-1:0]    in_bit0;
    logic [N_IN-1:0]    rise;
    logic [N_IN-1:0]    clr;
    logic               wr_ok;

    // Input capture stage(s) ahead of everything that looks at IN_DATA.
    always_comb begin
`ifdef MMIO_HUB_SYNC_EN
        meta_d = IN_DATA;
        sync_d = meta_q;
`else
        sync_d = IN_DATA;
`endif
    end

    // Next-state logic. Edge detection uses bit 0 of each synchronised
    // channel; a new rising edge overrides a W1C of the same bit.
    always_comb begin
        in_bit0    = '0;
        out_data_d = out_data_q;
        out_stb_d  = '0;
        mask_d     = mask_q;
        clr        = '0;
        wr_ok      = IOBUS_WR && mapped;
        for (int i = 0; i < N_IN; i++) begin
            in_bit0[i] = sync_q[i*W];
        end
        rise   = in_bit0 & ~prev_q;
        prev_d = in_bit0;
        for (int j = 0; j < N_OUT; j++) begin
            if (wr_ok && (slot == 32'(N_IN + j))) begin
                out_data_d[j*W +: W] = IOBUS_OUT[W-1:0];
                out_stb_d[j]         = 1'b1;
            end
        end
        if (wr_ok && (slot == 32'(S))) begin
            clr = IOBUS_OUT[N_IN-1:0];
        end
        if (wr_ok && (slot == 32'(S + 1))) begin
            mask_d = IOBUS_OUT[N_IN-1:0];
        end
        pend_d = (pend_q & ~clr) | rise;
        irq_d  = |(pend_q & mask_q);
    end

    // All state clears on reset, so a write in flight when RST_N drops is lost.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
`ifdef MMIO_HUB_SYNC_EN
            meta_q     <= '0;
`endif
            sync_q     <= '0;
            prev_q     <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            irq_q      <= 1'b0;
            out_data_q <= '0;
            out_stb_q  <= '0;
        end else begin
`ifdef MMIO_HUB_SYNC_EN
            meta_q     <= meta_d;
`endif
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            irq_q      <= irq_d;
            out_data_q <= out_data_d;
            out_stb_q  <= out_stb_d;
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        IOBUS_IN = '0;
        if (mapped) begin
            for (int i = 0; i < N_IN; i++) begin
                if (slot == 32'(i)) IOBUS_IN[W-1:0] = sync_q[i*W +: W];
            end
            for (int j = 0; j < N_OUT; j++) begin
                if (slot == 32'(N_IN + j)) IOBUS_IN[W-1:0] = out_data_q[j*W +: W];
            end
            if (slot == 32'(S))     IOBUS_IN[N_IN-1:0] = pend_q;
            if (slot == 32'(S + 1)) IOBUS_IN[N_IN-1:0] = mask_q;
        end
    end

    assign OUT_DATA = out_data_q;
    assign OUT_STB  = out_stb_q;
    assign IRQ      = irq_q;

endmodule

// File: doc/otter_mmio_hub.md
# otter_mmio_hub

Parametrised memory-mapped I/O hub between the OTTER MCU IOBUS and board peripherals. It replaces hand-written per-peripheral decode with a slot-indexed map, and provides:
- `N_OUT` write registers, each with a one-cycle write strobe.
- `N_IN` synchronised input channels.
- Rising-edge interrupt capture with mask and write-1-to-clear status.

It sits in the top-level wrapper on the MCU clock, between the MCU IOBUS ports and peripherals (LEDs, seven-segment display, VGA framebuffer, switches, buttons).

## Interface
Parameters:
- `N_OUT`, 4, number of output register slots (1–16)
- `N_IN`, 2, number of input channel slots (1–16)
- `W`, 16, data width of every channel (1–32)
- `BASE`, 32'h1100_0000, address of slot 0
- `SLOT_SH`, 18, log2 of slot spacing (slot k at `BASE + (k << SLOT_SH)`)

Ports:
- `CLK`  in  1  MCU clock; all state on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `IOBUS_ADDR`  in  32  bus address
- `IOBUS_OUT`  in  32  write data from MCU
- `IOBUS_WR`  in  1  write enable, sampled on `CLK` edge
- `IOBUS_IN`  out  32  read data to MCU (combinational from address and state)
- `IN_DATA`  in  `N_IN*W`  raw peripheral inputs; channel i = bits [i*W +: W]
- `OUT_DATA`  out  `N_OUT*W`  output registers; channel j = bits [j*W +: W]
- `OUT_STB`  out  `N_OUT`  one-cycle pulse when slot j is written
- `IRQ`  out  1  registered interrupt request to MCU `INTR`

## Operation
Slot map (address must equal `BASE + (k << SLOT_SH)` exactly; any other address is unmapped):
- Slots 0..`N_IN`-1: input channel i. Read returns the synchronised value, zero-extended. Writes are ignored.
- Slots `N_IN`..`N_IN+N_OUT`-1: output channel j = k−`N_IN`.
  - Write loads `IOBUS_OUT[W-1:0]` into `OUT_DATA` channel j and pulses `OUT_STB[j]`.
  - Read returns the current register value.
- Slot `S = N_IN+N_OUT`: `IRQ_PEND`.
  - Read returns `pend[N_IN-1:0]`.
  - Write clears each bit where `IOBUS_OUT` has a 1 (write-1-to-clear).
- Slot `S+1`: `IRQ_MASK`. Read/write of `mask[N_IN-1:0]`.
- Unmapped reads return 0. Unmapped writes have no effect.

Interrupts and strobes:
- Bit 0 of each synchronised input channel is edge-monitored against its previous value `prev[i]`. A 0→1 transition sets `pend[i]`.
- If a set and a W1C clear of the same bit occur in the same cycle, the set wins.
- `IRQ` <= |(`pend` & `mask`), registered.
- `OUT_STB` is registered: high for exactly the one cycle following each accepted write. Back-to-back writes to the same slot give a strobe in each following cycle.

Reset (`RST_N` low, asynchronous):
- `OUT_DATA`, `OUT_STB`, `pend`, `mask`, `IRQ`, synchroniser flops and `prev` all clear to 0.
- `IOBUS_IN` is then 0 for output, status and mask slots.
- Reset asserted mid-write discards the write.
- A level already high on an input at reset release produces a pending edge once it propagates through the synchroniser, because `prev` resets to 0.

## Timing
- Write: accepted on the `CLK` edge where `IOBUS_WR`=1. `OUT_DATA` holds the new value and `OUT_STB` is 1 from that edge to the next; the read-back is visible in the same cycle as the strobe.
- Input read latency (with sync): an input change before edge 1 is visible on `IOBUS_IN` after edge 2.
- Interrupt latency (with sync):
  - `pend` sets at edge 3.
  - `IRQ` rises at edge 4 if masked in.
- Clear: after a W1C write at edge n, `IRQ` falls at edge n+1 unless another enabled bit is pending or a new edge arrived.
- Mask write: `IRQ` follows at the next edge.

## Configuration
- `MMIO_HUB_SYNC_EN` defined: two-flop synchroniser on every `IN_DATA` bit; latencies as above.
- `MMIO_HUB_SYNC_EN` undefined: single register stage.
  - Input read visible after edge 1.
  - `pend` sets at edge 2.
  - `IRQ` rises at edge 3.
- Map and all other behaviour are identical in both builds.

## Test plan
All scenarios use defaults and `MMIO_HUB_SYNC_EN` defined unless noted.
1. Reset, then read all 8 slots (0x11000000..0x111C0000) -> every read returns 0; `OUT_STB`=0, `IRQ`=0.
2. Write 0xABCD to 0x11080000, then 0x1234 to 0x110C0000 on consecutive cycles -> `OUT_STB`=4'b0001 then 4'b0010, each for one cycle; read-back returns 0x0000ABCD and 0x00001234.
3. Set `IN_DATA` ch1 to 0x00FF -> read 0x11040000 returns 0xFF two edges later. Write to 0x11040000 -> no state change.
4. Write mask 0x3 to 0x111C0000, then raise `IN_DATA` ch0 bit 0 -> `pend`=0x1 at edge 3, `IRQ`=1 at edge 4. Write 0x1 to 0x11180000 -> `IRQ`=0 at the next edge.
5. Issue a W1C of ch0 in the same cycle a new ch0 rising edge is detected -> `pend[0]` stays 1 and `IRQ` stays high.
6. Assert `RST_N` low asynchronously mid-cycle during a write to 0x11080000 -> `OUT_DATA` is 0 immediately and remains 0 after release. Repeat with `MMIO_HUB_SYNC_EN` undefined -> interrupt latency is 3 edges.
